// File: rtl/ni_flit_ejector_pkg.sv
// ni_flit_ejector_pkg: flit field index helpers and state enums
// shared by the NI ejector, its interface and its per-VC FIFO.
// Flit layout: [Fw-1]=hdr [Fw-2]=tail [Fw-3:Fpay]=one-hot VC
// [Fpay-1:0]=payload, with Fw = 2+V+Fpay.
package ni_flit_ejector_pkg;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_PKT  = 1'b1
   } rx_state_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   localparam int PAY_LSB = 0;

   function automatic int flit_w(input int v, input int fpay);
      return 2 + v + fpay;
   endfunction

   function automatic int hdr_bit(input int v, input int fpay);
      return 1 + v + fpay;
   endfunction

   function automatic int tail_bit(input int v, input int fpay);
      return v + fpay;
   endfunction

   function automatic int vc_msb(input int v, input int fpay);
      return v + fpay - 1;
   endfunction

   function automatic int vc_lsb(input int fpay);
      return fpay;
   endfunction

   function automatic int pay_msb(input int fpay);
      return fpay - 1;
   endfunction

endpackage

// File: rtl/ni_flit_ejector_if.sv
// ni_flit_ejector_if: router-side flit/credit signals and core-side
// valid/ready output bundle of the NI ejector.
// slave  (ejector): in flit_in, flit_in_wr, out_ready;
//                   out credit_out, out_flit, out_vc, out_valid, err_o
// master (env)    : the reverse directions.
interface ni_flit_ejector_if
   import ni_flit_ejector_pkg::*;
#(
   parameter int V    = 2,
   parameter int Fpay = 32
);
   localparam int Fw = flit_w(V, Fpay);

   logic [Fw-1:0] flit_in;
   logic          flit_in_wr;
   logic [V-1:0]  credit_out;
   logic [Fw-1:0] out_flit;
   logic [V-1:0]  out_vc;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    err_o;

   modport slave (
      input  flit_in, flit_in_wr, out_ready,
      output credit_out, out_flit, out_vc, out_valid, err_o
   );

   modport master (
      output flit_in, flit_in_wr, out_ready,
      input  credit_out, out_flit, out_vc, out_valid, err_o
   );

endinterface

// File: rtl/ni_vc_fifo.sv
// ni_vc_fifo: single-VC B-deep flit FIFO with full/empty/count.
// Ports: clk, reset (sync, active-high), i_wr/i_din push,
// i_rd pop, o_dout head, o_full, o_empty, o_count occupancy.
module ni_vc_fifo #(
   parameter int W = 36,
   parameter int B = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_wr,
   input  logic [W-1:0]         i_din,
   input  logic                 i_rd,
   output logic [W-1:0]         o_dout,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [$clog2(B):0]   o_count
);
   localparam int AW = $clog2(B);

   logic [W-1:0]  r_mem [B];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_pop   = i_rd & ~o_empty;
   // a push into a full FIFO is only taken when a pop frees the slot
   assign w_push  = i_wr & (~o_full | w_pop);
   assign o_full  = (r_count == (AW+1)'(B));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

endmodule

// File: rtl/ni_flit_ejector.sv
// ni_flit_ejector: per-VC flit buffers from the router local port,
// packet-atomic round-robin delivery to the core, credit return.
// Ports: clk, reset (sync, active-high), io_bus (slave modport).
// Macro NI_EJECT_ERR_CHECK_EN enables RX FSMs and err_o detection.
module ni_flit_ejector
   import ni_flit_ejector_pkg::*;
#(
   parameter int V    = 2,
   parameter int Fpay = 32,
   parameter int B    = 4
) (
   input  logic                clk,
   input  logic                reset,
   ni_flit_ejector_if.slave    io_bus
);
   localparam int Fw   = flit_w(V, Fpay);
   localparam int TAIL = tail_bit(V, Fpay);
   localparam int HDR  = hdr_bit(V, Fpay);
   localparam int VMSB = vc_msb(V, Fpay);
   localparam int VLSB = vc_lsb(Fpay);
   localparam int VW   = (V > 1) ? $clog2(V) : 1;
   localparam int CW   = $clog2(B) + 1;

   logic [V-1:0]  w_vc;
   logic          w_vc_ok;
   logic [V-1:0]  w_wr;
   logic [V-1:0]  w_pop;
   logic [V-1:0]  w_full;
   logic [V-1:0]  w_empty;
   logic [CW-1:0] w_cnt [V];
   logic [Fw-1:0] w_head [V];
   logic [V-1:0]  w_grant;
   logic [VW-1:0] w_gidx;
   logic          w_valid;
   logic          w_gtail;
   logic          w_ghdr;
   logic          w_any_pop;

   arb_state_e    r_arb;
   arb_state_e    w_arb_nxt;
   logic [VW-1:0] r_lock;
   logic [VW-1:0] w_lock_nxt;
   logic [VW-1:0] r_prio;
   logic [VW-1:0] w_prio_nxt;
   logic [V-1:0]  r_credit;

   assign w_vc = io_bus.flit_in[VMSB:VLSB];

`ifdef NI_EJECT_ERR_CHECK_EN
   assign w_vc_ok = $onehot(w_vc);
`else
   assign w_vc_ok = 1'b1;
`endif

   assign w_wr  = {V{io_bus.flit_in_wr & w_vc_ok}} & w_vc;
   assign w_pop = w_grant & {V{io_bus.out_ready}};

   genvar g;
   generate
      for (g = 0; g < V; g++) begin : g_vc
         ni_vc_fifo #(
            .W (Fw),
            .B (B)
         ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (w_wr[g]),
            .i_din   (io_bus.flit_in),
            .i_rd    (w_pop[g]),
            .o_dout  (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_cnt[g])
         );

         a_cnt : assert property (
            @(posedge clk) disable iff (reset)
            w_cnt[g] <= CW'(B)
         );
      end
   endgenerate

   // grant: locked VC only, else first non-empty VC from r_prio on;
   // scanning offsets downward lets the smallest offset win
   always_comb begin
      int j;
      w_grant = '0;
      w_gidx  = '0;
      j       = 0;
      if (r_arb == ARB_LOCK) begin
         if (!w_empty[r_lock]) begin
            w_grant[r_lock] = 1'b1;
            w_gidx          = r_lock;
         end
      end else begin
         for (int k = V - 1; k >= 0; k--) begin
            j = (int'(r_prio) + k) % V;
            if (!w_empty[j]) begin
               w_grant    = '0;
               w_grant[j] = 1'b1;
               w_gidx     = VW'(j);
            end
         end
      end
   end

   assign w_valid   = |w_grant;
   assign w_any_pop = |w_pop;

   assign io_bus.out_flit  = w_valid ? w_head[w_gidx] : '0;
   assign io_bus.out_vc    = w_grant;
   assign io_bus.out_valid = w_valid;

   assign w_ghdr  = io_bus.out_flit[HDR];
   assign w_gtail = io_bus.out_flit[TAIL];

   always_comb begin
      w_arb_nxt  = r_arb;
      w_lock_nxt = r_lock;
      w_prio_nxt = r_prio;
      if (w_any_pop) begin
         w_prio_nxt = (w_gidx == VW'(V - 1)) ? '0 : w_gidx + 1'b1;
      end
      case (r_arb)
         ARB_IDLE: begin
            // a multi-flit header pins the output to its VC
            if (w_valid && w_ghdr && !w_gtail) begin
               w_arb_nxt  = ARB_LOCK;
               w_lock_nxt = w_gidx;
            end
         end
         ARB_LOCK: begin
            if (w_any_pop && w_gtail) w_arb_nxt = ARB_IDLE;
         end
         default: w_arb_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_arb    <= ARB_IDLE;
         r_lock   <= '0;
         r_prio   <= '0;
         r_credit <= '0;
      end else begin
         r_arb    <= w_arb_nxt;
         r_lock   <= w_lock_nxt;
         r_prio   <= w_prio_nxt;
         r_credit <= w_pop;
      end
   end

   assign io_bus.credit_out = r_credit;

`ifdef NI_EJECT_ERR_CHECK_EN
   rx_state_e  r_rx     [V];
   rx_state_e  w_rx_nxt [V];
   logic [V-1:0] w_proto;
   logic         w_hdr;
   logic         w_tail;
   logic         w_full_wr;
   logic         w_bad_vc;
   logic [1:0]   r_err;

   assign w_hdr  = io_bus.flit_in[HDR];
   assign w_tail = io_bus.flit_in[TAIL];

   // a header is legal only in RX_IDLE, body/tail only in RX_PKT
   always_comb begin
      w_proto = '0;
      for (int v = 0; v < V; v++) begin
         w_rx_nxt[v] = r_rx[v];
         if (w_wr[v]) begin
            if (w_hdr == (r_rx[v] == RX_PKT)) w_proto[v] = 1'b1;
            w_rx_nxt[v] = w_tail ? RX_IDLE : RX_PKT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < V; v++) r_rx[v] <= RX_IDLE;
      end else begin
         for (int v = 0; v < V; v++) r_rx[v] <= w_rx_nxt[v];
      end
   end

   assign w_full_wr = |(w_wr & w_full & ~w_pop);
   assign w_bad_vc  = io_bus.flit_in_wr & ~$onehot(w_vc);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= '0;
      end else begin
         r_err[0] <= r_err[0] | w_full_wr;
         r_err[1] <= r_err[1] | w_bad_vc | (|w_proto);
      end
   end

   assign io_bus.err_o = r_err;
`else
   assign io_bus.err_o = '0;
`endif

endmodule

// File: tb/tb_ni_flit_ejector.sv
// tb_ni_flit_ejector: directed vectors for ni_flit_ejector with
// V=2, Fpay=32, B=4; immediate assertions at each check point.
module tb_ni_flit_ejector;

`ifdef NI_EJECT_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   int   ncred;

   ni_flit_ejector_if #(.V(2), .Fpay(32)) bus ();

   ni_flit_ejector #(
      .V    (2),
      .Fpay (32),
      .B    (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [35:0] mk(input logic h, input logic t,
                                      input logic [1:0] vc,
                                      input logic [31:0] p);
      return {h, t, vc, p};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drv(input logic [35:0] f);
      bus.flit_in    = f;
      bus.flit_in_wr = 1'b1;
   endtask

   task automatic idle_wr;
      bus.flit_in    = '0;
      bus.flit_in_wr = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.flit_in    = '0;
      bus.flit_in_wr = 1'b0;
      bus.out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid",  bus.out_valid,  1'b0);
      chk("rst_credit", bus.credit_out, 2'b00);
      chk("rst_err",    bus.err_o,      2'b00);
      reset = 1'b0;

      // 3-flit packet on VC1, core always ready
      bus.out_ready = 1'b1;
      drv(mk(1, 0, 2'b10, 32'hA1)); tick;
      chk("p3_valid0", bus.out_valid, 1'b1);
      chk("p3_flit0",  bus.out_flit,  mk(1, 0, 2'b10, 32'hA1));
      chk("p3_vc0",    bus.out_vc,    2'b10);
      chk("p3_cred0",  bus.credit_out, 2'b00);
      drv(mk(0, 0, 2'b10, 32'hA2)); tick;
      chk("p3_flit1",  bus.out_flit,  mk(0, 0, 2'b10, 32'hA2));
      chk("p3_cred1",  bus.credit_out, 2'b10);
      drv(mk(0, 1, 2'b10, 32'hA3)); tick;
      chk("p3_flit2",  bus.out_flit,  mk(0, 1, 2'b10, 32'hA3));
      chk("p3_vc2",    bus.out_vc,    2'b10);
      chk("p3_cred2",  bus.credit_out, 2'b10);
      idle_wr(); tick;
      chk("p3_valid3", bus.out_valid, 1'b0);
      chk("p3_cred3",  bus.credit_out, 2'b10);
      tick;
      chk("p3_cred4",  bus.credit_out, 2'b00);
      chk("p3_err",    bus.err_o,      2'b00);

      // interleaved 2-flit packets on VC0/VC1, delivered whole
      bus.out_ready = 1'b0;
      drv(mk(1, 0, 2'b01, 32'hB0)); tick;
      drv(mk(1, 0, 2'b10, 32'hC0)); tick;
      drv(mk(0, 1, 2'b01, 32'hB1)); tick;
      drv(mk(0, 1, 2'b10, 32'hC1)); tick;
      idle_wr();
      bus.out_ready = 1'b1;
      chk("il_flit0", bus.out_flit, mk(1, 0, 2'b01, 32'hB0));
      chk("il_vc0",   bus.out_vc,   2'b01);
      tick;
      chk("il_flit1", bus.out_flit, mk(0, 1, 2'b01, 32'hB1));
      tick;
      chk("il_flit2", bus.out_flit, mk(1, 0, 2'b10, 32'hC0));
      chk("il_vc2",   bus.out_vc,   2'b10);
      chk("il_cred2", bus.credit_out, 2'b01);
      tick;
      chk("il_flit3", bus.out_flit, mk(0, 1, 2'b10, 32'hC1));
      tick;
      chk("il_valid4", bus.out_valid, 1'b0);
      chk("il_err",    bus.err_o,     2'b00);
      tick;

      // VC0 full, write and pop in the same cycle
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv(mk(1, 1, 2'b01, 32'h20 + i)); tick;
      end
      chk("fp_head", bus.out_flit, mk(1, 1, 2'b01, 32'h20));
      bus.out_ready = 1'b1;
      drv(mk(1, 1, 2'b01, 32'h24)); tick;
      idle_wr();
      chk("fp_err", bus.err_o, 2'b00);
      for (int i = 0; i < 4; i++) begin
         chk("fp_flit", bus.out_flit, mk(1, 1, 2'b01, 32'h21 + i));
         tick;
      end
      chk("fp_empty", bus.out_valid, 1'b0);
      tick;

      // overflow VC0 with core stalled
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv(mk(1, 1, 2'b01, 32'h10 + i)); tick;
      end
      chk("of_err4", bus.err_o, 2'b00);
      drv(mk(1, 1, 2'b01, 32'h14)); tick;
      idle_wr();
      chk("of_err5", bus.err_o, ERR_EN ? 2'b01 : 2'b00);
      bus.out_ready = 1'b1;
      ncred = 0;
      for (int i = 0; i < 4; i++) begin
         chk("of_flit", bus.out_flit, mk(1, 1, 2'b01, 32'h10 + i));
         tick;
         ncred += int'(bus.credit_out[0]);
      end
      chk("of_empty", bus.out_valid, 1'b0);
      tick;
      ncred += int'(bus.credit_out[0]);
      chk("of_ncred", ncred, 4);

`ifdef NI_EJECT_ERR_CHECK_EN
      // bad VC field: dropped, flagged, no credit
      drv(mk(1, 1, 2'b11, 32'h55)); tick;
      idle_wr();
      chk("bv_err",    bus.err_o,     2'b11);
      chk("bv_valid0", bus.out_valid, 1'b0);
      tick;
      chk("bv_cred",   bus.credit_out, 2'b00);
      chk("bv_valid1", bus.out_valid, 1'b0);
`endif

      // reset with a partial packet buffered on VC1
      bus.out_ready = 1'b0;
      drv(mk(1, 0, 2'b10, 32'h70)); tick;
      drv(mk(0, 0, 2'b10, 32'h71)); tick;
      idle_wr();
      chk("mr_pre", bus.out_valid, 1'b1);
      reset = 1'b1; tick;
      reset = 1'b0;
      chk("mr_valid",  bus.out_valid,  1'b0);
      chk("mr_credit", bus.credit_out, 2'b00);
      chk("mr_err",    bus.err_o,      2'b00);
      bus.out_ready = 1'b1;
      drv(mk(1, 1, 2'b01, 32'h80)); tick;
      chk("mr_valid0", bus.out_valid, 1'b1);
      chk("mr_flit0",  bus.out_flit,  mk(1, 1, 2'b01, 32'h80));
      drv(mk(1, 1, 2'b10, 32'h81)); tick;
      idle_wr();
      chk("mr_flit1",  bus.out_flit,  mk(1, 1, 2'b10, 32'h81));
      chk("mr_cred0",  bus.credit_out, 2'b01);
      tick;
      chk("mr_cred1",  bus.credit_out, 2'b10);
      chk("mr_valid2", bus.out_valid, 1'b0);
      chk("mr_err2",   bus.err_o,     2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
